update_obstacle_array: RTL
==========================

Name: update_obstacle_array

Overview:
Parametrised successor to the single-obstacle updater. Manages NUM_OBS independent obstacle slots that scroll from Y_START toward Y_MIN. Each slot waits a pseudo-random number of update ticks before it spawns, and on spawn it receives a random lane and sprite. Sits between the game-tick generator and the sprite renderer; its outputs feed the renderer and the collision/score logic.

Parameters:
NUM_OBS, 4, number of obstacle slots (1..8)
NUM_LANES, 2, lanes; power of two
X_BASE, 95, x of lane 0
X_PITCH, 40, x step per lane; X_BASE+(NUM_LANES-1)*X_PITCH must be <= 255
Y_START, 419, spawn y
Y_MIN, 36, lowest legal y
NUM_SPRITES, 4, sprite ids; power of two, <= 16
MIN_WAIT, 8, minimum wait in ticks
WAIT_BITS, 5, random wait range is 0..2^WAIT_BITS-1 added to MIN_WAIT
LFSR_SEED, 16'hACE1, LFSR reset value; must be nonzero

Ports:
clock  in  1  system clock
reset  in  1  synchronous, active-high
update  in  1  single-cycle tick strobe; all motion is gated by it
run  in  1  0 = freeze all slots (LFSR keeps running)
speed  in  4  pixels moved per tick
xSprite  out  NUM_OBS*8  slot i at bits [8i+7:8i]
ySprite  out  NUM_OBS*9  slot i at bits [9i+8:9i]
spriteId  out  NUM_OBS*4  slot i at bits [4i+3:4i]
active  out  NUM_OBS  slot i is visible
passed  out  1  one-clock pulse when at least one slot despawns

Behaviour:
- Single clock domain. All state changes only on clock edges where reset=0, update=1 and run=1, except the LFSR, which advances every clock.
- Reset: xSprite=X_BASE and ySprite=Y_START for every slot; spriteId=0; active=0; passed=0. LFSR loads LFSR_SEED. Slot i enters WAIT with wait_cnt = MIN_WAIT*(i+1), which staggers the first spawns.
- LFSR: 16-bit Galois, taps 16,14,13,11.
- Per-slot FSM, states WAIT, SPAWN, MOVE:
  - WAIT: if wait_cnt>0, decrement it. If wait_cnt==0 and the slot holds the spawn grant, go to SPAWN.
  - SPAWN (lasts one tick):
    - ySprite=Y_START
    - xSprite = X_BASE + lane*X_PITCH, with lane = lfsr[7:0] & (NUM_LANES-1)
    - spriteId = lfsr[11:8] & (NUM_SPRITES-1)
    - active=1; go to MOVE
  - MOVE:
    - If ySprite < Y_MIN + speed: active=0, ySprite=Y_START, assert passed; reload wait_cnt = MIN_WAIT + lfsr[WAIT_BITS-1:0]; go to WAIT.
    - Otherwise ySprite -= speed.
- Arithmetic: the Y_MIN+speed compare is done at 10 bits, so ySprite never underflows below Y_MIN.
- speed=0: MOVE slots hold position indefinitely; no despawn occurs.
- Spawn arbitration: at most one slot spawns per tick. Among WAIT slots with wait_cnt==0, the lowest index wins; the others stay in WAIT with wait_cnt=0 and retry next tick.
- Despawn and spawn may occur on the same tick in different slots.
- passed: registered, high for exactly one clock following the tick on which one or more slots despawn. Multiple despawns in the same tick produce a single pulse.
- update while run=0 is ignored; state and outputs hold.
- Reset asserted mid-operation overrides update and returns all slots to the reset state on that same edge.
- Latency: update sampled at edge n gives new outputs valid after edge n.

Optional Feature:
UPDATE_OBSTACLE_SPEEDUP_EN
- Defined: adds parameter SPEEDUP_PASSES (default 8) and an internal speed offset, 0..15. The offset increments by 1 after every SPEEDUP_PASSES despawn ticks. Effective speed = min(speed+offset, 15), used for both the move and the despawn compare. Reset clears the offset.
- Undefined: effective speed = speed; no extra registers.

Decomposition:
- Shared package: obstacle FSM state encoding (WAIT=0, SPAWN=1, MOVE=2), default screen bounds (Y_START=419, Y_MIN=36, X_BASE=95), and the LFSR tap constant.
- Sub-module obstacle_slot: one FSM plus x/y/id/wait registers. It takes a grant, the random bits and the effective speed, and returns a request and a despawn flag.
- Top level holds the LFSR, the priority arbiter, the optional speedup, and the output packing.

Test Plan:
1. Reset with NUM_OBS=4 -> all active=0, every ySprite=419, every xSprite=95; slot0 spawns on update tick 9 (MIN_WAIT=8 plus the SPAWN tick).
2. Single active slot, speed=4, y=44 -> next tick y=40. The tick after: 40 < 36+4 is false, so y=36. The tick after that: 36 < 40, so despawn with active=0 and a one-clock passed pulse.
3. Force slots 1 and 3 to wait_cnt=0 on the same tick -> only slot 1 spawns; slot 3 spawns on the following tick.
4. speed=0 for 100 ticks -> every y unchanged, passed never asserted.
5. run=0 with update pulsing for 20 clocks -> all outputs frozen; after run=1 they resume from the frozen values.
6. With UPDATE_OBSTACLE_SPEEDUP_EN defined, SPEEDUP_PASSES=2, speed=14 -> after 4 despawn ticks the effective speed saturates at 15 (y decrements by 15 per tick).

Source files
------------

// File: rtl/update_obstacle_array_pkg.sv
// Shared definitions for the obstacle array: slot FSM encoding, default screen bounds,
// and the 16-bit Galois LFSR (taps 16,14,13,11) step function.
package update_obstacle_array_pkg;

    typedef enum logic [1:0] {
        ST_WAIT  = 2'd0,
        ST_SPAWN = 2'd1,
        ST_MOVE  = 2'd2
    } obs_state_e;

    localparam int DEF_Y_START = 419;
    localparam int DEF_Y_MIN   = 36;
    localparam int DEF_X_BASE  = 95;

    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    function automatic logic [15:0] lfsr_step(input logic [15:0] s);
        return {1'b0, s[15:1]} ^ (s[0] ? LFSR_TAPS : 16'h0000);
    endfunction

endpackage

// File: rtl/update_obstacle_array_slot.sv
// One obstacle slot: WAIT/SPAWN/MOVE FSM with its own x/y/id/wait registers.
// Spawn values are loaded on the granting tick; SPAWN then holds one tick before motion starts.
module update_obstacle_array_slot
    import update_obstacle_array_pkg::*;
#(
    parameter int NUM_LANES   = 2,
    parameter int X_BASE      = DEF_X_BASE,
    parameter int X_PITCH     = 40,
    parameter int Y_START     = DEF_Y_START,
    parameter int Y_MIN       = DEF_Y_MIN,
    parameter int NUM_SPRITES = 4,
    parameter int MIN_WAIT    = 8,
    parameter int WAIT_BITS   = 5,
    parameter int WAIT_W      = 16,
    parameter int INIT_WAIT   = 8
) (
    input  logic        clock_i,
    input  logic        reset_i,
    input  logic        tick_i,
    input  logic        grant_i,
    input  logic [11:0] rnd_i,
    input  logic [3:0]  speed_i,
    output logic        req_o,
    output logic        despawn_o,
    output logic        active_o,
    output logic [7:0]  x_o,
    output logic [8:0]  y_o,
    output logic [3:0]  id_o
);

    obs_state_e        state_q;
    logic [WAIT_W-1:0] wait_q;
    logic [7:0]        x_q;
    logic [8:0]        y_q;
    logic [3:0]        id_q;
    logic              active_q;

    logic [7:0] lane;
    logic [7:0] lane_x;
    logic [9:0] y_limit;
    logic       at_bottom;

    assign lane      = rnd_i[7:0] & 8'(NUM_LANES - 1);
    assign lane_x    = 8'(X_BASE + int'(lane) * X_PITCH);
    assign y_limit   = 10'(Y_MIN) + {6'b0, speed_i};
    assign at_bottom = {1'b0, y_q} < y_limit;

    assign req_o     = (state_q == ST_WAIT) && (wait_q == '0);
    assign despawn_o = tick_i && (state_q == ST_MOVE) && at_bottom;

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            state_q  <= ST_WAIT;
            wait_q   <= WAIT_W'(INIT_WAIT);
            x_q      <= 8'(X_BASE);
            y_q      <= 9'(Y_START);
            id_q     <= '0;
            active_q <= 1'b0;
        end else if (tick_i) begin
            case (state_q)
                ST_WAIT: begin
                    if (wait_q != '0) begin
                        wait_q <= wait_q - 1'b1;
                    end else if (grant_i) begin
                        state_q  <= ST_SPAWN;
                        y_q      <= 9'(Y_START);
                        x_q      <= lane_x;
                        id_q     <= rnd_i[11:8] & 4'(NUM_SPRITES - 1);
                        active_q <= 1'b1;
                    end
                end
                ST_SPAWN: state_q <= ST_MOVE;
                ST_MOVE: begin
                    if (at_bottom) begin
                        active_q <= 1'b0;
                        y_q      <= 9'(Y_START);
                        wait_q   <= WAIT_W'(MIN_WAIT) + WAIT_W'(rnd_i[WAIT_BITS-1:0]);
                        state_q  <= ST_WAIT;
                    end else begin
                        y_q <= y_q - {5'b0, speed_i};
                    end
                end
                default: state_q <= ST_WAIT;
            endcase
        end
    end

    assign active_o = active_q;
    assign x_o      = x_q;
    assign y_o      = y_q;
    assign id_o     = id_q;

endmodule

// File: rtl/update_obstacle_array.sv
// NUM_OBS scrolling obstacle slots sharing one LFSR and a lowest-index spawn arbiter.
// Optional feature macro: UPDATE_OBSTACLE_SPEEDUP_EN (speed offset grows with despawns).
module update_obstacle_array
    import update_obstacle_array_pkg::*;
#(
    parameter int          NUM_OBS     = 4,
    parameter int          NUM_LANES   = 2,
    parameter int          X_BASE      = DEF_X_BASE,
    parameter int          X_PITCH     = 40,
    parameter int          Y_START     = DEF_Y_START,
    parameter int          Y_MIN       = DEF_Y_MIN,
    parameter int          NUM_SPRITES = 4,
    parameter int          MIN_WAIT    = 8,
    parameter int          WAIT_BITS   = 5,
    parameter logic [15:0] LFSR_SEED   = 16'hACE1
`ifdef UPDATE_OBSTACLE_SPEEDUP_EN
    , parameter int        SPEEDUP_PASSES = 8
`endif
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 update,
    input  logic                 run,
    input  logic [3:0]           speed,
    output logic [NUM_OBS*8-1:0] xSprite,
    output logic [NUM_OBS*9-1:0] ySprite,
    output logic [NUM_OBS*4-1:0] spriteId,
    output logic [NUM_OBS-1:0]   active,
    output logic                 passed
);

    localparam int WAIT_W = 16;

    logic [15:0]        lfsr_q;
    logic               passed_q;
    logic               tick;
    logic [NUM_OBS-1:0] req;
    logic [NUM_OBS-1:0] grant;
    logic [NUM_OBS-1:0] despawn;
    logic [3:0]         eff_speed;

    assign tick  = update && run;
    // Isolate the lowest set request bit: only one slot may spawn per tick.
    assign grant = req & (~req + NUM_OBS'(1));

    always_ff @(posedge clock) begin
        if (reset) begin
            lfsr_q   <= LFSR_SEED;
            passed_q <= 1'b0;
        end else begin
            lfsr_q   <= lfsr_step(lfsr_q);
            passed_q <= tick && (|despawn);
        end
    end

`ifdef UPDATE_OBSTACLE_SPEEDUP_EN
    localparam int PC_W = $clog2(SPEEDUP_PASSES + 1);

    logic [3:0]      offset_q;
    logic [PC_W-1:0] pass_cnt_q;
    logic [4:0]      speed_sum;

    always_ff @(posedge clock) begin
        if (reset) begin
            offset_q   <= '0;
            pass_cnt_q <= '0;
        end else if (tick && (|despawn)) begin
            if (pass_cnt_q == PC_W'(SPEEDUP_PASSES - 1)) begin
                pass_cnt_q <= '0;
                if (offset_q != 4'd15) offset_q <= offset_q + 4'd1;
            end else begin
                pass_cnt_q <= pass_cnt_q + 1'b1;
            end
        end
    end

    assign speed_sum = {1'b0, speed} + {1'b0, offset_q};
    assign eff_speed = (speed_sum > 5'd15) ? 4'd15 : speed_sum[3:0];
`else
    assign eff_speed = speed;
`endif

    for (genvar i = 0; i < NUM_OBS; i++) begin : g_slot
        update_obstacle_array_slot #(
            .NUM_LANES  (NUM_LANES),
            .X_BASE     (X_BASE),
            .X_PITCH    (X_PITCH),
            .Y_START    (Y_START),
            .Y_MIN      (Y_MIN),
            .NUM_SPRITES(NUM_SPRITES),
            .MIN_WAIT   (MIN_WAIT),
            .WAIT_BITS  (WAIT_BITS),
            .WAIT_W     (WAIT_W),
            .INIT_WAIT  (MIN_WAIT * (i + 1))
        ) u_slot (
            .clock_i  (clock),
            .reset_i  (reset),
            .tick_i   (tick),
            .grant_i  (grant[i]),
            .rnd_i    (lfsr_q[11:0]),
            .speed_i  (eff_speed),
            .req_o    (req[i]),
            .despawn_o(despawn[i]),
            .active_o (active[i]),
            .x_o      (xSprite[8*i +: 8]),
            .y_o      (ySprite[9*i +: 9]),
            .id_o     (spriteId[4*i +: 4])
        );
    end

    assign passed = passed_q;

endmodule
